kf8259_bus_control_logic: RTL
=============================

Name: kf8259_bus_control_logic

Overview:
- Upstream CPU-bus front end of the 8259A.
- Synchronises the asynchronous CPU strobes (chip_select_n, read_enable_n, write_enable_n, address A0) and the data bus into the clock domain.
- Tracks each bus cycle with a small FSM and decodes completed writes into the one-cycle command strobes and internal_data_bus consumed by KF8259_Control_Logic.
- Also supplies the synchronised read level and A0 used by the read/data-out path.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each control-strobe synchroniser (legal range 2..4)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
chip_select_n  input  1  CPU chip select, active low, asynchronous
read_enable_n  input  1  CPU RD#, active low, asynchronous
write_enable_n  input  1  CPU WR#, active low, asynchronous
address  input  1  CPU A0
data_bus_in  input  8  CPU data bus, write direction
internal_data_bus  output  8  data captured during the last committed write
write_initial_command_word_1  output  1  one-cycle strobe, ICW1
write_initial_command_word_2_4  output  1  one-cycle strobe, A0=1 write
write_operation_control_word_1  output  1  one-cycle strobe, A0=1 write
write_operation_control_word_2  output  1  one-cycle strobe, OCW2
write_operation_control_word_3  output  1  one-cycle strobe, OCW3
read  output  1  level: synchronised read cycle active with chip selected
write  output  1  level: synchronised write cycle active with chip selected
read_address  output  1  A0 captured during the current or last read
bus_conflict  output  1  high while in the CONFLICT state

Behaviour:
- Reset:
  - All synchroniser flops load 1 (inactive).
  - FSM enters IDLE.
  - All strobes, read, write and bus_conflict are 0.
  - internal_data_bus = 8'h00; read_address = 0.
- Synchronisers: cs_n, rd_n and wr_n each pass through SYNC_STAGES flops, giving cs_s, rd_s and wr_s (active-high after inversion).
- Data/address capture: address and data_bus_in are registered with a single flop per bit every cycle, without multi-stage synchronisation. The write protocol guarantees they are stable for the whole WR# low window.
- FSM states:
  - IDLE → WRITE when cs_s & wr_s & ~rd_s.
  - IDLE → READ when cs_s & rd_s & ~wr_s.
  - IDLE → CONFLICT when cs_s & rd_s & wr_s.
  - WRITE: each cycle with cs_s high, latch data into internal_data_bus shadow and A0 into a write-address shadow; set flag cs_seen.
    - wr_s falling to 0 → IDLE and commit if cs_seen.
    - rd_s rising → CONFLICT, no commit.
  - READ: read = 1 while cs_s & rd_s; read_address latched on entry.
    - rd_s falling → IDLE.
    - wr_s rising → CONFLICT.
  - CONFLICT: bus_conflict = 1; no strobes; read = write = 0. Stay until rd_s = wr_s = 0, then → IDLE.
- write = 1 in WRITE while cs_s is high.
- Commit, registered, asserted exactly one cycle on the cycle after the WRITE → IDLE transition. internal_data_bus updates on the same edge as the strobe and holds until the next commit.
  - A0=0, D4=1 → write_initial_command_word_1.
  - A0=0, D4=0, D3=0 → write_operation_control_word_2.
  - A0=0, D4=0, D3=1 → write_operation_control_word_3.
  - A0=1 → write_initial_command_word_2_4 and write_operation_control_word_1 both pulse. Downstream control logic qualifies them by its own command state.
- Latency: a write strobe is high in cycle SYNC_STAGES+2, counted from the first rising edge that samples WR# high.
- Back-to-back writes: a new write may enter WRITE in the same cycle its predecessor's strobe is high. Strobes never merge. Each committed write yields exactly one strobe cycle.
- CS released mid-write: if cs_s drops during WRITE, capture stops but cs_seen keeps the last valid data and address, and the write still commits when WR# rises.
- Reset mid-cycle: the in-flight operation is discarded with no strobe. After reset release, a still-low WR# is re-detected through the synchronisers and committed normally on its rising edge.

Decomposition:
- Shared package kf8259_pkg:
  - FSM state enum (IDLE, WRITE, READ, CONFLICT).
  - Data-bus bit-index constants ICW1_SEL_BIT = 4, OCW3_SEL_BIT = 3.
  - Strobe bundle typedef.
- One sub-module, kf8259_sync_bit: a parameterised SYNC_STAGES-deep synchroniser with reset value 1, instantiated three times.

Test Plan:
- ICW1: CS#=0, A0=0, WR# low 4 cycles with data 8'h13, then WR# high → write_initial_command_word_1 high exactly one cycle at SYNC_STAGES+2; internal_data_bus = 8'h13; no other strobe.
- A0=1 write of 8'hFB → write_initial_command_word_2_4 and write_operation_control_word_1 pulse together for one cycle; internal_data_bus = 8'hFB.
- A0=0 writes 8'h20 then 8'h0A, separated by one idle cycle → one write_operation_control_word_2 pulse, then one write_operation_control_word_3 pulse; internal_data_bus steps 8'h20 → 8'h0A.
- Read with A0=1, RD# low 5 cycles → read high for 5 cycles delayed by SYNC_STAGES; read_address = 1; no write strobes.
- RD# and WR# asserted together, data 8'h55 → bus_conflict high until both are released; no strobes; internal_data_bus unchanged.
- reset pulsed mid-write (data 8'h13) → all outputs 0 immediately; WR# still low after release, data 8'h17 → single ICW1 strobe with internal_data_bus = 8'h17.

Source files
------------

// File: rtl/kf8259_pkg.sv
// Types and constants shared across the kf8259 bus front end: the bus-cycle
// state enum, the command strobe bundle and the write-to-strobe decoder.
package kf8259_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    CONFLICT
  } bus_state_t;

  localparam int ICW1_SEL_BIT = 4;
  localparam int OCW3_SEL_BIT = 3;

  typedef struct packed {
    logic icw1;
    logic icw2_4;
    logic ocw1;
    logic ocw2;
    logic ocw3;
  } strobe_t;

  // A0=1 writes go to both ICW2-4 and OCW1; the control logic picks one.
  function automatic strobe_t decode_write(input logic a0, input logic [7:0] data);
    strobe_t s;
    s = '0;
    if (a0) begin
      s.icw2_4 = 1'b1;
      s.ocw1   = 1'b1;
    end else if (data[ICW1_SEL_BIT]) begin
      s.icw1 = 1'b1;
    end else if (data[OCW3_SEL_BIT]) begin
      s.ocw3 = 1'b1;
    end else begin
      s.ocw2 = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/kf8259_sync_bit.sv
// Multi-flop synchroniser for one asynchronous active-low strobe; resets to
// the inactive (high) level so nothing looks asserted right after reset.
module kf8259_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_reg <= '1;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/kf8259_bus_control_logic.sv
// CPU bus front end: synchronises the bus strobes, tracks each bus cycle and
// turns completed writes into one-cycle command strobes plus captured data.
module kf8259_bus_control_logic #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       read,
  output logic       write,
  output logic       read_address,
  output logic       bus_conflict
);
  import kf8259_pkg::*;

  // Bit order: [2]=CS#, [1]=RD#, [0]=WR#.
  logic [2:0] strobe_n_async;
  logic [2:0] strobe_n_sync;
  logic       cs_s, rd_s, wr_s;

  assign strobe_n_async = {chip_select_n, read_enable_n, write_enable_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    kf8259_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (strobe_n_async[gi]),
      .q    (strobe_n_sync[gi])
    );
  end

  assign cs_s = ~strobe_n_sync[2];
  assign rd_s = ~strobe_n_sync[1];
  assign wr_s = ~strobe_n_sync[0];

  // Single flop is enough: data and A0 are held stable across the WR# window,
  // which outlasts the longer strobe synchroniser delay.
  logic       address_reg;
  logic [7:0] data_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_reg <= 1'b0;
      data_reg    <= 8'h00;
    end else begin
      address_reg <= address;
      data_reg    <= data_bus_in;
    end
  end

  bus_state_t state_reg;
  logic [7:0] data_shadow_reg;
  logic       addr_shadow_reg;
  logic       cs_seen_reg;
  logic       commit_pending_reg;
  strobe_t    strobe_reg;
  logic [7:0] internal_data_bus_reg;
  logic       read_reg, write_reg, read_address_reg, bus_conflict_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg             <= IDLE;
      data_shadow_reg       <= 8'h00;
      addr_shadow_reg       <= 1'b0;
      cs_seen_reg           <= 1'b0;
      commit_pending_reg    <= 1'b0;
      strobe_reg            <= '0;
      internal_data_bus_reg <= 8'h00;
      read_reg              <= 1'b0;
      write_reg             <= 1'b0;
      read_address_reg      <= 1'b0;
      bus_conflict_reg      <= 1'b0;
    end else begin
      commit_pending_reg <= 1'b0;
      strobe_reg         <= '0;
      read_reg           <= 1'b0;
      write_reg          <= 1'b0;
      bus_conflict_reg   <= 1'b0;

      // Commit happens one cycle after leaving WRITE, so a new write may
      // already be entering WRITE on this same edge without disturbing it.
      if (commit_pending_reg) begin
        strobe_reg            <= decode_write(addr_shadow_reg, data_shadow_reg);
        internal_data_bus_reg <= data_shadow_reg;
      end

      case (state_reg)
        IDLE: begin
          if (cs_s && wr_s && rd_s) begin
            state_reg        <= CONFLICT;
            bus_conflict_reg <= 1'b1;
          end else if (cs_s && wr_s) begin
            state_reg       <= WRITE;
            write_reg       <= 1'b1;
            data_shadow_reg <= data_reg;
            addr_shadow_reg <= address_reg;
            cs_seen_reg     <= 1'b1;
          end else if (cs_s && rd_s) begin
            state_reg        <= READ;
            read_reg         <= 1'b1;
            read_address_reg <= address_reg;
          end
        end
        WRITE: begin
          if (rd_s) begin
            state_reg        <= CONFLICT;
            bus_conflict_reg <= 1'b1;
            cs_seen_reg      <= 1'b0;
          end else if (!wr_s) begin
            state_reg          <= IDLE;
            commit_pending_reg <= cs_seen_reg;
            cs_seen_reg        <= 1'b0;
          end else begin
            write_reg <= cs_s;
            // Losing CS mid-write freezes the shadow at the last valid value.
            if (cs_s) begin
              data_shadow_reg <= data_reg;
              addr_shadow_reg <= address_reg;
              cs_seen_reg     <= 1'b1;
            end
          end
        end
        READ: begin
          if (wr_s) begin
            state_reg        <= CONFLICT;
            bus_conflict_reg <= 1'b1;
          end else if (!rd_s) begin
            state_reg <= IDLE;
          end else begin
            read_reg <= cs_s;
          end
        end
        CONFLICT: begin
          if (!rd_s && !wr_s) begin
            state_reg <= IDLE;
          end else begin
            bus_conflict_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign internal_data_bus              = internal_data_bus_reg;
  assign write_initial_command_word_1   = strobe_reg.icw1;
  assign write_initial_command_word_2_4 = strobe_reg.icw2_4;
  assign write_operation_control_word_1 = strobe_reg.ocw1;
  assign write_operation_control_word_2 = strobe_reg.ocw2;
  assign write_operation_control_word_3 = strobe_reg.ocw3;
  assign read                           = read_reg;
  assign write                          = write_reg;
  assign read_address                   = read_address_reg;
  assign bus_conflict                   = bus_conflict_reg;

endmodule
